damage_calc: RTL and testbench

DAMAGE_CALC -- requirements
Module: damage_calc

---
 rtl/damage_calc.sv | 189 ++++++++++++++++++
 tb/tb_damage_calc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/damage_calc.sv
// Battlefront damage pass: for each lane, read unit A and unit B, apply mutual
// damage computed from pre-damage values, write back living units, flag dead lanes.
module damage_calc #(
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             damageSCEN,
  input  logic             damageCalcACK,
  output logic             damageCalcDone,
  output logic [3:0]       rdAddr,
  input  logic [15:0]      rdData,
  output logic             wrEn,
  output logic [3:0]       wrAddr,
  output logic [7:0]       wrHealth,
  output logic [LANES-1:0] deadA,
  output logic [LANES-1:0] deadB
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CALC = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       lane_q, lane_d;
  logic [15:0]      unit_a_q, unit_a_d;
  logic [7:0]       hp_b_q, hp_b_d;
  logic [7:0]       new_a_q, new_a_d;
  logic [7:0]       new_b_q, new_b_d;
  logic             done_q, done_d;
  logic [3:0]       rd_addr_q, rd_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_health_q, wr_health_d;
  logic [LANES-1:0] dead_a_q, dead_a_d;
  logic [LANES-1:0] dead_b_q, dead_b_d;

  // Health of defender x after a hit from attacker y; a dead or unarmed attacker does nothing,
  // otherwise a hit always costs at least 1.
  function automatic logic [7:0] new_health(input logic [7:0] hx, input logic [3:0] defx,
                                            input logic [7:0] hy, input logic [3:0] atky);
    logic [7:0] dmg;
    if (hy == 8'd0 || atky == 4'd0) begin
      dmg = 8'd0;
    end else if (atky > defx) begin
      dmg = {4'd0, atky - defx};
    end else begin
      dmg = 8'd1;
    end
    if (hx > dmg) begin
      new_health = hx - dmg;
    end else begin
      new_health = 8'd0;
    end
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= 3'd0;
      unit_a_q    <= 16'd0;
      hp_b_q      <= 8'd0;
      new_a_q     <= 8'd0;
      new_b_q     <= 8'd0;
      done_q      <= 1'b0;
      rd_addr_q   <= 4'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_health_q <= 8'd0;
      dead_a_q    <= '0;
      dead_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      unit_a_q    <= unit_a_d;
      hp_b_q      <= hp_b_d;
      new_a_q     <= new_a_d;
      new_b_q     <= new_b_d;
      done_q      <= done_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_health_q <= wr_health_d;
      dead_a_q    <= dead_a_d;
      dead_b_q    <= dead_b_d;
    end
  end

  // Next state; outputs are precomputed for the state being entered so they appear registered.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    unit_a_d    = unit_a_q;
    hp_b_d      = hp_b_q;
    new_a_d     = new_a_q;
    new_b_d     = new_b_q;
    done_d      = 1'b0;
    rd_addr_d   = 4'd0;
    wr_en_d     = 1'b0;
    wr_addr_d   = 4'd0;
    wr_health_d = 8'd0;
    dead_a_d    = dead_a_q;
    dead_b_d    = dead_b_q;
    case (state_q)
      IDLE: begin
        if (damageSCEN) begin
          state_d   = RD_A;
          lane_d    = 3'd0;
          dead_a_d  = '0;
          dead_b_d  = '0;
          rd_addr_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        state_d   = RD_B;
        rd_addr_d = {1'b1, lane_q};
      end
      RD_B: begin
        unit_a_d = rdData;
        state_d  = CALC;
      end
      CALC: begin
        hp_b_d  = rdData[15:8];
        new_a_d = new_health(unit_a_q[15:8], unit_a_q[3:0], rdData[15:8], rdData[7:4]);
        new_b_d = new_health(rdData[15:8], rdData[3:0], unit_a_q[15:8], unit_a_q[7:4]);
        state_d = WR_A;
        if (unit_a_q[15:8] != 8'd0) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = {1'b0, lane_q};
          wr_health_d = new_a_d;
        end else begin
          wr_en_d = 1'b0;
        end
      end
      WR_A: begin
        dead_a_d[lane_q] = (new_a_q == 8'd0);
        state_d          = WR_B;
        if (hp_b_q != 8'd0) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = {1'b1, lane_q};
          wr_health_d = new_b_q;
        end else begin
          wr_en_d = 1'b0;
        end
      end
      WR_B: begin
        dead_b_d[lane_q] = (new_b_q == 8'd0);
        if (lane_q == 3'(LANES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          lane_d    = lane_q + 3'd1;
          state_d   = RD_A;
          rd_addr_d = {1'b0, lane_q + 3'd1};
        end
      end
      DONE: begin
        if (damageCalcACK) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign damageCalcDone = done_q;
  assign rdAddr         = rd_addr_q;
  assign wrEn           = wr_en_q;
  assign wrAddr         = wr_addr_q;
  assign wrHealth       = wr_health_q;
  assign deadA          = dead_a_q;
  assign deadB          = dead_b_q;

endmodule

// File: tb/tb_damage_calc.sv
// Directed bench for damage_calc: a timeline-level model of the pass plus literal checks.
module tb_damage_calc;
  localparam int LANES = 8;

  logic             clk = 1'b0;
  logic             reset, scen, ack;
  logic             done;
  logic [3:0]       rd_addr, wr_addr;
  logic [15:0]      rd_data;
  logic             wr_en;
  logic [7:0]       wr_health;
  logic [LANES-1:0] dead_a, dead_b;

  damage_calc #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset), .damageSCEN(scen), .damageCalcACK(ack),
    .damageCalcDone(done), .rdAddr(rd_addr), .rdData(rd_data),
    .wrEn(wr_en), .wrAddr(wr_addr), .wrHealth(wr_health),
    .deadA(dead_a), .deadB(dead_b)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int obs_hp [16];
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int new_hp(input int hx, input int dx, input int hy, input int ay);
    int d;
    d = (hy == 0 || ay == 0) ? 0 : ((ay > dx) ? ay - dx : 1);
    return (hx > d) ? hx - d : 0;
  endfunction

  function automatic int hp(input int a);  return int'(mem[a][15:8]); endfunction
  function automatic int atk(input int a); return int'(mem[a][7:4]);  endfunction
  function automatic int dfn(input int a); return int'(mem[a][3:0]);  endfunction

  function automatic int res_a(input int l); return new_hp(hp(l), dfn(l), hp(8+l), atk(8+l)); endfunction
  function automatic int res_b(input int l); return new_hp(hp(8+l), dfn(8+l), hp(l), atk(l)); endfunction

  function automatic logic [LANES-1:0] exp_dead(input bit army_b);
    logic [LANES-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) v[l] = ((army_b ? res_b(l) : res_a(l)) == 0);
    return v;
  endfunction

  // Pass timeline model: cycle k after the start edge, 5 cycles per lane.
  bit m_act, m_done, m_dead_known;
  int m_k;
  logic [LANES-1:0] m_dead_a, m_dead_b;
  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0; m_done <= 1'b0; m_k <= 0;
      m_dead_known <= 1'b1; m_dead_a <= '0; m_dead_b <= '0;
    end else if (m_act) begin
      if (m_k == 5*LANES-1) begin
        m_act <= 1'b0; m_done <= 1'b1; m_dead_known <= 1'b1;
        m_dead_a <= exp_dead(1'b0); m_dead_b <= exp_dead(1'b1);
      end else begin
        m_k <= m_k + 1;
      end
    end else if (m_done) begin
      if (ack) m_done <= 1'b0;
    end else if (scen) begin
      m_act <= 1'b1; m_k <= 0; m_dead_known <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int lane, ph, e_rd, e_we, e_wa, e_wh;
    if (chk_en) begin
      lane = m_k / 5; ph = m_k % 5;
      e_rd = 0; e_we = 0; e_wa = 0; e_wh = 0;
      if (m_act) begin
        if (ph == 0) e_rd = lane;
        if (ph == 1) e_rd = 8 + lane;
        if (ph == 3 && hp(lane) != 0) begin e_we = 1; e_wa = lane; e_wh = res_a(lane); end
        if (ph == 4 && hp(8+lane) != 0) begin e_we = 1; e_wa = 8 + lane; e_wh = res_b(lane); end
      end
      chk("done", int'(done), int'(m_done));
      chk("rdAddr", int'(rd_addr), e_rd);
      chk("wrEn", int'(wr_en), e_we);
      chk("wrAddr", int'(wr_addr), e_wa);
      chk("wrHealth", int'(wr_health), e_wh);
      if (m_dead_known) begin
        chk("deadA", int'(dead_a), int'(m_dead_a));
        chk("deadB", int'(dead_b), int'(m_dead_b));
      end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        obs_hp[wr_addr] = int'(wr_health);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start();
    for (int i = 0; i < 16; i++) obs_hp[i] = 255;
    wr_cnt = 0;
    scen = 1'b1;
    tick();
    scen = 1'b0;
  endtask

  // Edges counted from the sampling edge until done; optionally pulse start mid-pass.
  task automatic wait_done(input int pulse_at, output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      scen = (n == pulse_at);
      tick();
      n++;
    end
    scen = 1'b0;
    if (n >= 200) chk("done_timeout", 0, 1);
  endtask

  task automatic load_alive();
    for (int l = 0; l < 8; l++) begin
      mem[l]   = {8'(100 + l), 4'd6, 4'd2};
      mem[8+l] = {8'(80 + l), 4'd5, 4'd3};
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; scen = 1'b0; ack = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_done", int'(done), 0);
    chk("rst_wrEn", int'(wr_en), 0);
    chk("rst_dead", int'({dead_a, dead_b}), 0);
    reset = 1'b0;
    tick();

    // Mixed table: lane0 plain exchange, lane1 minimum-damage kill, lane2 dead A.
    load_alive();
    mem[0]  = {8'd20, 4'd9, 4'd2};  mem[8]  = {8'd10, 4'd5, 4'd4};
    mem[1]  = {8'd5,  4'd3, 4'd0};  mem[9]  = {8'd1,  4'd2, 4'd7};
    mem[2]  = {8'd0,  4'd4, 4'd1};  mem[10] = {8'd50, 4'd15, 4'd3};
    chk("model_pin_a0", res_a(0), 17);
    chk("model_pin_b1", res_b(1), 0);
    start();
    wait_done(-1, n);
    chk("pass1_latency", n, 40);
    chk("lane0_A", obs_hp[0], 17);
    chk("lane0_B", obs_hp[8], 5);
    chk("lane1_B", obs_hp[9], 0);
    chk("lane2_A_nowrite", obs_hp[2], 255);
    chk("lane2_B", obs_hp[10], 50);
    chk("deadB1", int'(dead_b[1]), 1);
    chk("deadA2", int'(dead_a[2]), 1);
    chk("pass1_writes", wr_cnt, 15);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_done_low", int'(done), 0);

    // All alive; stray starts mid-pass and alongside ACK are ignored.
    load_alive();
    start();
    wait_done(11, n);
    chk("pass2_latency", n, 40);
    repeat (10) tick();
    chk("held_done", int'(done), 1);
    ack = 1'b1; scen = 1'b1; tick(); ack = 1'b0; scen = 1'b0;
    chk("ack2_done_low", int'(done), 0);
    repeat (3) tick();
    chk("no_restart_rd", int'(rd_addr), 0);
    chk("no_restart_done", int'(done), 0);
    chk("pass2_writes", wr_cnt, 16);

    // Reset during WR_B of lane 3, then a clean restart.
    start();
    repeat (19) tick();
    reset = 1'b1;
    tick();
    chk("abort_writes", wr_cnt, 8);
    chk("abort_outs", int'({done, rd_addr, wr_en, wr_addr, wr_health}), 0);
    chk("abort_dead", int'({dead_a, dead_b}), 0);
    reset = 1'b0;
    tick();
    start();
    wait_done(-1, n);
    chk("pass3_latency", n, 40);
    chk("pass3_writes", wr_cnt, 16);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
